sd_block_responder: RTL

//  Target side of the sd_lba/sd_rd/sd_wr/sd_ack block handshake used by the disk front ends (HDD, floppy_track).

---
 rtl/sd_block_responder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sd_block_responder.sv
// rtl/sd_block_responder.sv - target side of the sd_lba/sd_rd/sd_wr/sd_ack 512-byte block handshake
// Optional feature macro: SD_RESP_STATS_EN adds rd_count/wr_count completed-block counters.
// ACK_DELAY: sd_ack rises ACK_DELAY+1 clock edges after the edge that accepts the request.
// The byte-address calculation {lba,9'b0}+offset is done at ADDR_W bits, so upper bits truncate.
module sd_block_responder #(
    parameter logic [31:0] IMG_BLOCKS = 32'd65536,
    parameter logic [7:0]  ACK_DELAY  = 8'd4,
    parameter int          ADDR_W     = 32
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    output logic              sd_buff_wr,
    input  logic [7:0]        sd_buff_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              lba_err
`ifdef SD_RESP_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DELAY    = 3'd1;
    localparam logic [2:0] S_RD_FETCH = 3'd2;
    localparam logic [2:0] S_RD_PUSH  = 3'd3;
    localparam logic [2:0] S_WR_ADDR  = 3'd4;
    localparam logic [2:0] S_WR_STORE = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [2:0]  state;
    logic [7:0]  delay_cnt;
    logic [31:0] lba_q;
    logic        dir_rd;
    logic        lba_oor;
    logic [8:0]  offset;
    logic [7:0]  wdata_q;
    logic        wr_first;

    // Out-of-range blocks never touch the backing store; the handshake still runs.
    assign mem_rd     = (state == S_RD_FETCH) && !lba_oor;
    assign mem_wr     = (state == S_WR_STORE) && !lba_oor;
    assign sd_buff_wr = (state == S_RD_PUSH);
    assign busy       = (state != S_IDLE);
    assign mem_addr   = ADDR_W'({lba_q, 9'd0}) + ADDR_W'(offset);
    // On the first store cycle the initiator RAM output is used directly so a
    // zero-wait memory sees valid data; later wait cycles use the latched copy.
    assign mem_wdata  = wr_first ? sd_buff_din : wdata_q;

    // Main transfer sequencer: request latch, ack delay, per-byte read/write loop.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            delay_cnt    <= 8'd0;
            lba_q        <= 32'd0;
            dir_rd       <= 1'b0;
            lba_oor      <= 1'b0;
            lba_err      <= 1'b0;
            offset       <= 9'd0;
            sd_ack       <= 1'b0;
            sd_buff_addr <= 9'd0;
            sd_buff_dout <= 8'd0;
            wdata_q      <= 8'd0;
            wr_first     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if ((sd_rd || sd_wr) && !sd_ack) begin
                        lba_q     <= sd_lba;
                        dir_rd    <= sd_rd;
                        lba_oor   <= (sd_lba >= IMG_BLOCKS);
                        if (sd_lba >= IMG_BLOCKS) begin
                            lba_err <= 1'b1;
                        end
                        delay_cnt <= 8'd0;
                        state     <= S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (delay_cnt == ACK_DELAY) begin
                        sd_ack <= 1'b1;
                        offset <= 9'd0;
                        if (dir_rd) begin
                            state <= S_RD_FETCH;
                        end else begin
                            sd_buff_addr <= 9'd0;
                            state        <= S_WR_ADDR;
                        end
                    end else begin
                        delay_cnt <= delay_cnt + 8'd1;
                    end
                end
                S_RD_FETCH: begin
                    if (lba_oor) begin
                        sd_buff_dout <= 8'h00;
                        sd_buff_addr <= offset;
                        state        <= S_RD_PUSH;
                    end else if (mem_ready) begin
                        sd_buff_dout <= mem_rdata;
                        sd_buff_addr <= offset;
                        state        <= S_RD_PUSH;
                    end
                end
                S_RD_PUSH: begin
                    if (offset == 9'd511) begin
                        sd_ack <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        offset <= offset + 9'd1;
                        state  <= S_RD_FETCH;
                    end
                end
                S_WR_ADDR: begin
                    wr_first <= 1'b1;
                    state    <= S_WR_STORE;
                end
                S_WR_STORE: begin
                    wr_first <= 1'b0;
                    if (wr_first) begin
                        wdata_q <= sd_buff_din;
                    end
                    if (lba_oor || mem_ready) begin
                        if (offset == 9'd511) begin
                            sd_ack <= 1'b0;
                            state  <= S_DONE;
                        end else begin
                            offset       <= offset + 9'd1;
                            sd_buff_addr <= offset + 9'd1;
                            state        <= S_WR_ADDR;
                        end
                    end
                end
                S_DONE: begin
                    // Wait for the initiator to drop its level so it cannot retrigger.
                    if (!sd_rd && !sd_wr) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SD_RESP_STATS_EN
    logic done_rd;
    logic done_wr;

    assign done_rd = (state == S_RD_PUSH) && (offset == 9'd511);
    assign done_wr = (state == S_WR_STORE) && (lba_oor || mem_ready) && (offset == 9'd511);

    // Completed-block counters, bumped on the edge that enters DONE; wrap naturally.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else begin
            if (done_rd) begin
                rd_count <= rd_count + 16'd1;
            end
            if (done_wr) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end
`endif

endmodule
